// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Drives one external combinational 4-bit adder slice to add two WIDTH-bit operands,
//   one nibble per clock, LSB nibble first. The carry between nibbles is chained
//   through an internal register. Valid/ready handshakes are used on both sides.
//
//   Optional feature macro: NIBBLE_SERIAL_ADD_CTRL_SUB_EN
//     defined   : adds input `sub`; sub=1 computes op_a - op_b (cout=1 -> no borrow)
//     undefined : add only, cin honoured
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid, in_ready    operand handshake (ready only in IDLE)
//   op_a, op_b, cin       operands and carry-in for nibble 0
//   sub                   (SUB_EN only) subtract select, latched at accept
//   add_a, add_b, add_cin to the adder slice (0 outside RUN)
//   add_s, add_cout       from the adder slice, sampled in the same cycle
//   out_valid, out_ready  result handshake
//   sum, cout             result and final carry-out, valid with out_valid

module nibble_serial_add_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    input  logic             sub,
`endif
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIBBLES = WIDTH / 4;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e                   state_q;
    logic [NIBBLES-1:0][3:0]  a_q;
    logic [NIBBLES-1:0][3:0]  b_q;
    logic [NIBBLES-1:0][3:0]  sum_q;
    logic                     carry_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     sub_q;

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
    logic sub_in;
    assign sub_in = sub;
`else
    logic sub_in;
    assign sub_in = 1'b0;
`endif

    assign sum = sum_q;

    // Slice drive is decoded from registered state only; zero outside RUN.
    always_comb begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        if (state_q == StRun) begin
            add_a   = a_q[idx_q];
            // Subtraction is a + ~b + 1; the +1 comes from the forced nibble-0 carry.
            add_b   = sub_q ? ~b_q[idx_q] : b_q[idx_q];
            add_cin = carry_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sub_q     <= 1'b0;
            cout      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        a_q      <= op_a;
                        b_q      <= op_b;
                        sub_q    <= sub_in;
                        carry_q  <= sub_in ? 1'b1 : cin;
                        idx_q    <= '0;
                        in_ready <= 1'b0;
                        state_q  <= StRun;
                    end
                end
                StRun: begin
                    sum_q[idx_q] <= add_s;
                    carry_q      <= add_cout;
                    if (idx_q == IDX_W'(NIBBLES - 1)) begin
                        cout      <= add_cout;
                        out_valid <= 1'b1;
                        idx_q     <= '0;
                        state_q   <= StDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                StDone: begin
                    // One bubble between operations: in_ready returns only in IDLE.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
module tb_nibble_serial_add_ctrl;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned NIBBLES = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             sub;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_s;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total = 0;
    int bad   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH-1:0] cur_a;
    logic [WIDTH-1:0] cur_b;
    logic             cur_sub;

    always #5 clk = ~clk;

    // Behavioural 4-bit ripple-carry slice.
    always_comb begin
        {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    end

    nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        .sub       (sub),
`endif
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_s     (add_s),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_add_a", add_a, 0);
        check("rst_add_b", add_b, 0);
        check("rst_add_cin", add_cin, 0);
    endtask

    // Present one operation at a negedge; returns after the accepting edge.
    task automatic start_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c, input logic s, input bit push);
        logic [WIDTH:0] e;
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", in_ready, 1);
        op_a     = a;
        op_b     = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        cur_a    = a;
        cur_b    = b;
`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        cur_sub  = s;
        if (s) e = {1'b0, a} + {1'b0, ~b} + 17'd1;
        else   e = {1'b0, a} + {1'b0, b} + {16'd0, c};
`else
        cur_sub  = 1'b0;
        e = {1'b0, a} + {1'b0, b} + {16'd0, c};
`endif
        if (push) exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        op_a     = 16'hDEAD;
        op_b     = 16'hBEEF;
        check("in_ready_after_accept", in_ready, 0);
    endtask

    // Walk the RUN phase, check latency and slice drive, then compare the result.
    task automatic finish_op(input bit drain, output logic [3:0] cins);
        logic [WIDTH:0] e;
        logic [3:0]     na;
        logic [3:0]     nb;
        int n = 0;
        cins = 4'd0;
        while (!out_valid && n < 20) begin
            if (n < int'(NIBBLES)) begin
                cins[n] = add_cin;
                na = 4'(cur_a >> (4 * n));
                nb = 4'(cur_b >> (4 * n));
                if (cur_sub) nb = ~nb;
                check("run_add_a", add_a, na);
                check("run_add_b", add_b, nb);
            end
            @(negedge clk);
            n++;
        end
        check("latency", n, NIBBLES);
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("sum", sum, e[WIDTH-1:0]);
            check("cout", cout, e[WIDTH]);
        end
        check("done_in_ready", in_ready, 0);
        check("done_add_cin", add_cin, 0);
        if (drain) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            check("drain_out_valid", out_valid, 0);
            check("drain_in_ready", in_ready, 1);
        end
    endtask

    initial begin
        logic [3:0] cins;
        logic [WIDTH-1:0] held_sum;
        logic held_cout;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        cur_a     = '0;
        cur_b     = '0;
        cur_sub   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;
        @(negedge clk);

        // Carry propagating over two nibbles.
        start_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
        finish_op(1'b1, cins);
        check("cin_sequence", cins, 4'b0110);

        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
        finish_op(1'b1, cins);

        start_op(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
        finish_op(1'b1, cins);

        // Backpressure: result held, in_valid ignored.
        start_op(16'h8000, 16'h8001, 1'b1, 1'b0, 1'b1);
        finish_op(1'b0, cins);
        held_sum  = 16'h0002;
        held_cout = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            op_a     = 16'h1111 * i;
            op_b     = 16'h0F0F;
            @(negedge clk);
            check("bp_out_valid", out_valid, 1);
            check("bp_in_ready", in_ready, 0);
            check("bp_sum", sum, held_sum);
            check("bp_cout", cout, held_cout);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);

        // Reset mid-RUN after the second nibble.
        start_op(16'hABCD, 16'h1111, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("mid_run_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1);
        finish_op(1'b1, cins);

`ifdef NIBBLE_SERIAL_ADD_CTRL_SUB_EN
        start_op(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1);
        finish_op(1'b1, cins);
        start_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1);
        finish_op(1'b1, cins);
`endif

        // A few random additions through the scoreboard.
        for (int i = 0; i < 6; i++) begin
            start_op(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b1);
            finish_op(1'b1, cins);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
